// File: rtl/data_mem_responder_pkg.sv
// Shared constants and FSM state encoding for the data-memory responder
// and the processor's load/store interface.
package data_mem_responder_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port synchronous word RAM, no reset, read-enabled output
// register so the read value holds between accesses.
module data_mem_responder_dmem_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store data-memory responder: request/response handshakes,
// configurable wait states, and a zeroing sweep after every reset.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IW = $clog2(DEPTH + 1);
    localparam int WW = cnt_w(WAIT_CYCLES + 1);

    localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [IW-1:0]   INIT_LAST = IW'(DEPTH - 1);
    localparam logic [WW-1:0]   WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WW'(WAIT_CYCLES - 1) : '0;

    state_t            r_state;
    state_t            w_next;
    logic [IW-1:0]     r_init_cnt;
    logic [WW-1:0]     r_wait_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_err;
    logic              r_rd_ok;

    logic              w_accept;
    logic              w_access;
    logic              w_acc_we;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_acc_wdata;
    logic              w_in_range;

    logic              w_ram_we;
    logic              w_ram_re;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;

    always_comb begin
        w_next   = r_state;
        w_access = 1'b0;
        w_accept = (r_state == ST_IDLE) && req_valid;
        unique case (r_state)
            ST_INIT: begin
                if (r_init_cnt == INIT_LAST) begin
                    w_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        w_next = ST_WAIT;
                    end else begin
                        w_next   = ST_RESP;
                        w_access = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_next   = ST_RESP;
                    w_access = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_INIT;
        endcase
    end

    // With zero wait states the access happens on the accept edge,
    // so the operands come straight from the request port.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_acc_we    = req_we;
            w_acc_addr  = req_addr;
            w_acc_wdata = req_wdata;
        end else begin
            w_acc_we    = r_we;
            w_acc_addr  = r_addr;
            w_acc_wdata = r_wdata;
        end
        w_in_range = {1'b0, w_acc_addr} < DEPTH_X;
    end

    always_comb begin
        w_ram_we    = w_access && w_acc_we && w_in_range;
        w_ram_re    = w_access && !w_acc_we && w_in_range;
        w_ram_addr  = w_acc_addr;
        w_ram_wdata = w_acc_wdata;
        if (r_state == ST_INIT) begin
            w_ram_we    = 1'b1;
            w_ram_re    = 1'b0;
            w_ram_addr  = ADDR_W'(r_init_cnt);
            w_ram_wdata = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_wait_cnt <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_rd_ok    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + IW'(1);
            end
            if (w_accept) begin
                r_we       <= req_we;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_wait_cnt <= WAIT_LOAD;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - WW'(1);
            end
            if (w_access) begin
                r_err   <= !w_in_range;
                r_rd_ok <= !w_acc_we && w_in_range;
            end
        end
    end

    data_mem_responder_dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // RAM output is only meaningful after an in-range load.
    assign rsp_rdata = r_rd_ok ? w_ram_rdata : '0;
    assign rsp_err   = r_err;
    assign rsp_valid = (r_state == ST_RESP);
    assign req_ready = (r_state == ST_IDLE);
    assign init_done = (r_state != ST_INIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two builds (256 words/1 wait, 200 words/0 wait),
// vector table, corner sequences and random traffic against a word-array model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        init_done [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [7:0]  req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl [2][256];

    typedef struct {
        int          d;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    data_mem_responder #(
        .DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(1)
    ) u_a (
        .clk(clk), .reset(rst[0]), .init_done(init_done[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    data_mem_responder #(
        .DATA_W(32), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(0)
    ) u_b (
        .clk(clk), .reset(rst[1]), .init_done(init_done[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    function automatic int dep(input int d);
        return (d == 1) ? 200 : 256;
    endfunction

    function automatic int wcy(input int d);
        return (d == 1) ? 0 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reset asserted immediately (may be mid-transaction), released on the
    // next falling edge; then the clear sweep is timed edge by edge.
    task automatic do_reset(input int d);
        int n;
        logic bad;
        rst[d] = 1'b1;
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b0;
        #1;
        chk($sformatf("d%0d_rst_rsp_valid", d), rsp_valid[d], 0);
        chk($sformatf("d%0d_rst_req_ready", d), req_ready[d], 0);
        chk($sformatf("d%0d_rst_init_done", d), init_done[d], 0);
        chk($sformatf("d%0d_rst_rdata", d), rsp_rdata[d], 0);
        chk($sformatf("d%0d_rst_err", d), rsp_err[d], 0);
        @(negedge clk);
        rst[d] = 1'b0;
        n = 0;
        bad = 1'b0;
        while (!init_done[d] && n < 400) begin
            @(posedge clk);
            n++;
            #1;
            if (!init_done[d] && (req_ready[d] || rsp_valid[d])) bad = 1'b1;
        end
        chk($sformatf("d%0d_init_cycles", d), n, dep(d));
        chk($sformatf("d%0d_init_quiet", d), bad, 0);
        for (int i = 0; i < 256; i++) mdl[d][i] = '0;
        @(negedge clk);
    endtask

    // One full transaction; called on a falling edge, returns on one.
    task automatic txn(input int d, input logic we, input logic [7:0] addr,
                       input logic [31:0] wdata, input int hold,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input string name);
        int n;
        int lat;
        logic [31:0] rd;
        logic er;
        logic stable;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        rsp_ready[d] = 1'b0;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk({name, "_accept_timeout"}, 0, 1);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, 1 + wcy(d));
        chk({name, "_rdata"}, rsp_rdata[d], exp_rd);
        chk({name, "_err"}, rsp_err[d], exp_err);
        rd = rsp_rdata[d];
        er = rsp_err[d];
        stable = (req_ready[d] === 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== rd ||
                rsp_err[d] !== er || req_ready[d] !== 1'b0) stable = 1'b0;
        end
        chk({name, "_hold_stable"}, stable, 1);
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk({name, "_rsp_drop"}, rsp_valid[d], 0);
        chk({name, "_ready_back"}, req_ready[d], 1);
        if (we && addr < dep(d)) mdl[d][addr] = wdata;
    endtask

    task automatic rand_txn(input int d, input logic [7:0] addr,
                            input string name);
        logic we;
        logic [31:0] wd;
        logic er;
        logic [31:0] rd;
        we = 1'($urandom_range(0, 1));
        wd = $urandom;
        er = (int'(addr) >= dep(d));
        rd = (!we && !er) ? mdl[d][addr] : 32'h0;
        txn(d, we, addr, wd, $urandom_range(0, 2), rd, er, name);
    endtask

    initial begin
        int acc_cyc[$];
        logic [7:0] acc_addr[$];
        int n_acc;
        int n_rsp;
        int c0;
        logic [7:0] a0;
        logic [31:0] exp_rd;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0;
            req_valid[d] = 1'b0;
            req_we[d] = 1'b0;
            req_addr[d] = '0;
            req_wdata[d] = '0;
            rsp_ready[d] = 1'b0;
        end
        #2;
        do_reset(0);
        do_reset(1);

        tbl.push_back('{0, 1'b0, 8'h7F, 32'h0, 0, 32'h0, 1'b0});
        tbl.push_back('{0, 1'b1, 8'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0});
        tbl.push_back('{0, 1'b0, 8'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{0, 1'b0, 8'h10, 32'h0, 5, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{0, 1'b1, 8'hFF, 32'h1, 1, 32'h0, 1'b0});
        tbl.push_back('{0, 1'b0, 8'hFF, 32'h0, 0, 32'h1, 1'b0});
        tbl.push_back('{1, 1'b1, 8'd220, 32'h1234, 0, 32'h0, 1'b1});
        tbl.push_back('{1, 1'b0, 8'd220, 32'h0, 0, 32'h0, 1'b1});
        tbl.push_back('{1, 1'b0, 8'd199, 32'h0, 0, 32'h0, 1'b0});
        tbl.push_back('{1, 1'b1, 8'd199, 32'h55, 2, 32'h0, 1'b0});
        tbl.push_back('{1, 1'b0, 8'd199, 32'h0, 0, 32'h55, 1'b0});
        tbl.push_back('{1, 1'b0, 8'd255, 32'h0, 0, 32'h0, 1'b1});
        tbl.push_back('{1, 1'b0, 8'd200, 32'h0, 0, 32'h0, 1'b1});

        foreach (tbl[i]) begin
            txn(tbl[i].d, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
                tbl[i].rd, tbl[i].err, $sformatf("vec%0d", i));
        end

        // Reset while a store sits in WAIT: no response, data cleared.
        txn(0, 1'b1, 8'h05, 32'hAAAA, 0, 32'h0, 1'b0, "pre_store");
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 8'h05;
        req_wdata[0] = 32'hCAFE;
        chk("wr_rst_ready", req_ready[0], 1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("wr_rst_in_wait", rsp_valid[0], 0);
        do_reset(0);
        txn(0, 1'b0, 8'h05, 32'h0, 0, 32'h0, 1'b0, "post_rst_load");

        // Reset while a response is pending drops rsp_valid at once.
        txn(0, 1'b1, 8'h22, 32'h77, 0, 32'h0, 1'b0, "pre_resp");
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 8'h22;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("resp_rst_valid_up", rsp_valid[0], 1);
        chk("resp_rst_rdata", rsp_rdata[0], 32'h77);
        do_reset(0);

        // Zero-wait build: back-to-back loads, one per two cycles.
        for (int i = 0; i < 256; i++) begin
            if (i < 200 && (i % 7 == 0)) begin
                txn(1, 1'b1, 8'(i), 32'hB000 + 32'(i), 0, 32'h0, 1'b0,
                    "tp_fill");
            end
        end
        n_acc = 0;
        n_rsp = 0;
        rsp_ready[1] = 1'b1;
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[1]  = 8'($urandom_range(0, 210));
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (rsp_valid[1]) begin
                if (acc_addr.size() == 0) begin
                    chk("tp_rsp_without_req", 1, 0);
                end else begin
                    a0 = acc_addr.pop_front();
                    c0 = acc_cyc.pop_front();
                    exp_rd = (a0 < 200) ? mdl[1][a0] : 32'h0;
                    chk($sformatf("tp_rdata_%0d", n_rsp), rsp_rdata[1], exp_rd);
                    chk($sformatf("tp_err_%0d", n_rsp), rsp_err[1],
                        32'(a0 >= 200));
                    chk($sformatf("tp_lat_%0d", n_rsp), cyc - c0, 1);
                end
                n_rsp++;
            end
            if (req_ready[1]) begin
                acc_addr.push_back(req_addr[1]);
                acc_cyc.push_back(cyc);
                n_acc++;
            end else begin
                req_addr[1] = 8'($urandom_range(0, 210));
            end
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b0;
        chk("tp_accepts", n_acc, 20);
        chk("tp_responses", n_rsp, 20);
        @(negedge clk);

        // Random traffic on both builds against the word-array model.
        for (int k = 0; k < 30; k++) begin
            rand_txn(0, 8'($urandom_range(0, 15)), $sformatf("rnd_a%0d", k));
            rand_txn(1, 8'($urandom_range(190, 215)), $sformatf("rnd_b%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
